// File: rtl/pulse_stretcher_pkg.sv
// Shared definitions for the multi-channel pulse stretcher: per-channel
// state encoding and the timer width helper.
package pulse_stretcher_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } ch_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Wide enough to hold the larger reload value; never narrower than 1 bit
    // so ON_CYCLES=OFF_CYCLES=1 still elaborates.
    function automatic int timer_width(input int on_cycles, input int off_cycles);
        int w;
        w = $clog2(max_int(on_cycles, off_cycles));
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pulse_stretch_ch.sv
// One stretcher channel: IDLE/ON/GAP sequencer with a reload timer, a
// saturating count of queued strobes and a sticky overflow flag.
module pulse_stretch_ch
    import pulse_stretcher_pkg::*;
#(
    parameter int ON_CYCLES  = 25_000_000,
    parameter int OFF_CYCLES = 12_500_000,
    parameter int PEND_W     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pulse,
    input  logic              clear_ovf,
    output logic              led,
    output ch_state_t         state,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int              TW       = timer_width(ON_CYCLES, OFF_CYCLES);
    localparam logic [TW-1:0]   ON_LOAD  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0]   OFF_LOAD = TW'(OFF_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    ch_state_t         state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              ovf_q, ovf_d;
    logic              led_q;
    logic              timer_done;
    logic              queued;
    logic              ovf_event;

    assign timer_done = (timer_q == '0);

    // A strobe is queued whenever the channel is mid-blink and cannot start
    // a blink from it in this cycle (everything except IDLE and GAP-end).
    assign queued = pulse && ((state_q == ST_ON) ||
                              ((state_q == ST_GAP) && !timer_done));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            led_q   <= (state_d == ST_ON);
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        pend_d    = pend_q;
        ovf_event = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pulse) begin
                    state_d = ST_ON;
                    timer_d = ON_LOAD;
                end
            end
            ST_ON: begin
                if (timer_done) begin
                    state_d = ST_GAP;
                    timer_d = OFF_LOAD;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_GAP: begin
                if (timer_done) begin
                    if ((pend_q != '0) || pulse) begin
                        state_d = ST_ON;
                        timer_d = ON_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                    // Strobe + dequeue cancel out; a lone strobe is consumed directly.
                    if ((pend_q != '0) && !pulse) begin
                        pend_d = pend_q - 1'b1;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase

        if (queued) begin
            if (pend_q == PEND_MAX) begin
                ovf_event = 1'b1;
            end else begin
                pend_d = pend_q + 1'b1;
            end
        end

        ovf_d = (ovf_q && !clear_ovf) || ovf_event;
    end

    assign led      = led_q;
    assign state    = state_q;
    assign pending  = pend_q;
    assign overflow = ovf_q;

endmodule

// File: rtl/pulse_stretcher.sv
// Multi-channel pulse stretcher: one independent stretcher per strobe input,
// with a shared overflow clear.
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int CH         = 4,
    parameter int ON_CYCLES  = 25_000_000,
    parameter int OFF_CYCLES = 12_500_000,
    parameter int PEND_W     = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CH-1:0] pulse_in,
    input  logic          clear_ovf,
    output logic [CH-1:0] led_out,
    output logic [CH-1:0] busy,
    output logic [CH-1:0] overflow
);

    ch_state_t         ch_state [CH];
    logic [PEND_W-1:0] ch_pend  [CH];

    for (genvar i = 0; i < CH; i++) begin : g_ch
        pulse_stretch_ch #(
            .ON_CYCLES  (ON_CYCLES),
            .OFF_CYCLES (OFF_CYCLES),
            .PEND_W     (PEND_W)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .pulse     (pulse_in[i]),
            .clear_ovf (clear_ovf),
            .led       (led_out[i]),
            .state     (ch_state[i]),
            .pending   (ch_pend[i]),
            .overflow  (overflow[i])
        );

        // Decoded from flops that reset asynchronously, so busy drops with rst_n.
        assign busy[i] = (ch_state[i] != ST_IDLE) || (ch_pend[i] != '0);
    end

endmodule

// File: doc/pulse_stretcher.md
# pulse_stretcher

Multi-channel pulse stretcher: turns single-cycle strobes (the output of the button pulser) into human-visible LED blinks of fixed on and off time. A strobe that arrives while a channel is still blinking is queued, so every strobe produces exactly one blink. It sits between the pulse-generating input logic and the board LEDs, and gives visual confirmation of each registered button press.

## Interface
- CH, 4, number of independent channels
- ON_CYCLES, 25_000_000, clock cycles the LED is held high per blink (>=1)
- OFF_CYCLES, 12_500_000, minimum low gap between consecutive blinks (>=1)
- PEND_W, 3, width of the per-channel pending-strobe counter; saturates at 2^PEND_W-1
- clk  input  1  system clock; the block uses this single clock only
- rst_n  input  1  reset, asynchronous, active-low
- pulse_in  input  CH  per-channel strobe, synchronous to clk; each high cycle counts as one strobe
- clear_ovf  input  1  synchronous clear of all overflow flags
- led_out  output  CH  stretched LED drive, registered
- busy  output  CH  channel not idle, or strobes pending
- overflow  output  CH  sticky: a strobe was dropped because pending was saturated

## Operation
- Per-channel FSM states: IDLE, ON, GAP. Encoding: IDLE=0, ON=1, GAP=2.
- IDLE with pulse_in=1: go to ON and load the timer with ON_CYCLES-1. The pending counter is not incremented.
- ON: timer counts down. At 0: go to GAP and load OFF_CYCLES-1.
- GAP: timer counts down. At 0:
  - if pending>0 or pulse_in=1: go to ON.
  - otherwise: go to IDLE.
- Pending counter:
  - A strobe in ON or GAP increments it.
  - A GAP-to-ON transition decrements it.
  - A strobe in the same cycle as a decrement leaves it unchanged.
  - In GAP-end with pending=0 and pulse_in=1: the strobe is consumed directly and pending stays 0.
- Saturation: if a strobe would increment pending when it is already 2^PEND_W-1, pending holds and overflow[i] is set.
- clear_ovf=1 clears all overflow bits. A new overflow event in the same cycle wins, so that bit reads 1.
- Outputs:
  - led_out[i] = (state==ON), registered.
  - busy[i] = (state!=IDLE) or (pending!=0).
- Timer width: $clog2(max(ON_CYCLES,OFF_CYCLES)). Arithmetic is unsigned. No wrap: the timer is only reloaded, never decremented below 0.

## Timing
- Reset (rst_n=0, asynchronous): all channels go to IDLE with timer=0 and pending=0. led_out, busy and overflow are all 0 immediately, without waiting for a clock edge.
- Reset mid-blink: the LED drops at once and queued strobes are discarded.
- Latency: a strobe sampled at edge t gives led_out=1 from edge t (visible in cycle t+1).
- Blink shape: led_out is high for exactly ON_CYCLES cycles, then low for exactly OFF_CYCLES cycles before the next queued blink.
- Back-to-back blink period: ON_CYCLES+OFF_CYCLES.
- Channels are fully independent; strobes on any combination of channels in the same cycle are allowed.
- A level held high for k cycles counts as k strobes, subject to saturation.

## Structure
- Package pulse_stretcher_pkg holds:
  - the state encoding constants
  - a clog2/max width helper
- Sub-module pulse_stretch_ch: one channel, containing the FSM, timer, pending counter and overflow flag.
- Top-level pulse_stretcher:
  - generates CH instances of pulse_stretch_ch
  - fans clear_ovf out to every instance
  - concatenates the per-channel outputs.

## Test plan
All scenarios use CH=2, ON_CYCLES=4, OFF_CYCLES=2, PEND_W=2.
- Reset: hold rst_n=0 with random pulse_in -> all outputs 0. Release with no strobes for 20 cycles -> outputs stay 0.
- Single strobe: pulse_in[0] at cycle 10 -> led_out[0]=1 in cycles 11-14, 0 in 15-16; busy[0]=1 in cycles 11-16, 0 from 17. Channel 1 stays untouched.
- Queue: strobes on ch0 at cycles 10, 12, 13 -> three blinks starting at cycles 11, 17, 23. busy is 0 from cycle 29; overflow stays 0.
- GAP-end collision: strobe at cycle 10 and a second strobe exactly at cycle 16 (last GAP cycle) -> second blink starts at cycle 17; pending never exceeds 0.
- Saturation: strobe at cycle 10, then 4 strobes at cycles 11-14 -> pending reaches 3 and overflow[0]=1 from cycle 15. Exactly 4 blinks occur. clear_ovf at cycle 40 -> overflow[0]=0 at cycle 41.
- Async reset mid-blink: rst_n=0 at cycle 13, between clock edges, with pending=2 -> led_out, busy and overflow go to 0 immediately. After release, no further blinks occur.
